// File: rtl/memory_access_unit_if.sv
// External memory bus between the memory access unit (master) and the memory (slave).
interface memory_access_unit_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we;
    logic        bus_req;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_addr, bus_wdata, bus_be, bus_we, bus_req,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_be, bus_we, bus_req,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/memory_access_unit.sv
// Runs one external bus transaction per request: byte/half/word loads and stores with
// little-endian lanes, alignment checks, wait states and a bounded ack timeout.
module memory_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_address,
    input  logic [31:0]           wdata,
    input  logic                  start,
    input  logic                  write,
    input  logic [1:0]            size,
    input  logic                  signed_load,
    memory_access_unit_if.master  bus,
    output logic [31:0]           rdata,
    output logic                  done,
    output logic                  abort,
    output logic                  busy
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        bus_we_q, bus_we_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic        busy_q, busy_d;
    logic        misaligned;

    function automatic logic [3:0] lane_enables(input logic [1:0] lo, input logic [1:0] sz);
        case (sz)
            2'b00:   lane_enables = 4'b0001 << lo;
            2'b01:   lane_enables = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then truncate and extend to the access size.
    function automatic logic [31:0] load_align(input logic [31:0] d, input logic [1:0] lo,
                                               input logic [1:0] sz, input logic sgn);
        logic [31:0] s;
        s = d >> {lo, 3'b000};
        case (sz)
            2'b00:   load_align = {{24{sgn & s[7]}}, s[7:0]};
            2'b01:   load_align = {{16{sgn & s[15]}}, s[15:0]};
            default: load_align = s;
        endcase
    endfunction

    always_comb begin
        misaligned = (size == 2'b11) ||
                     (size == 2'b01 && mem_address[0]) ||
                     (size == 2'b10 && mem_address[1:0] != 2'b00);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        signed_d    = signed_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_we_d    = bus_we_q;
        bus_req_d   = bus_req_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_lo_d = mem_address[1:0];
                    size_d    = size;
                    signed_d  = signed_load;
                    if (misaligned) begin
                        abort_d = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        cnt_d       = 8'd0;
                        bus_addr_d  = {mem_address[31:2], 2'b00};
                        bus_be_d    = lane_enables(mem_address[1:0], size);
                        bus_wdata_d = write ? lane_data(wdata, size) : 32'd0;
                        bus_we_d    = write;
                        bus_req_d   = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.bus_ack) begin
                    if (!bus_we_q)
                        rdata_d = load_align(bus.bus_rdata, addr_lo_q, size_q, signed_q);
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    bus_be_d  = 4'b0000;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    bus_be_d  = 4'b0000;
                    busy_d    = 1'b0;
                    abort_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            addr_lo_q   <= 2'b00;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'b0000;
            bus_we_q    <= 1'b0;
            bus_req_q   <= 1'b0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_we_q    <= bus_we_d;
            bus_req_q   <= bus_req_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_req   = bus_req_q;
    assign rdata         = rdata_q;
    assign done          = done_q;
    assign abort         = abort_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with hand-computed expected values.
module tb_memory_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_address;
    logic [31:0] wdata;
    logic        start;
    logic        write;
    logic [1:0]  size;
    logic        signed_load;
    logic [31:0] rdata;
    logic        done;
    logic        abort;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    memory_access_unit_if bus_if ();

    memory_access_unit #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_address (mem_address),
        .wdata       (wdata),
        .start       (start),
        .write       (write),
        .size        (size),
        .signed_load (signed_load),
        .bus         (bus_if),
        .rdata       (rdata),
        .done        (done),
        .abort       (abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one aligned access at cycle 0; the memory acks after 'waits' wait states.
    task automatic do_access(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                             input logic wr, input logic [1:0] sz, input logic sgn,
                             input int waits, input logic [31:0] bus_rd,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        mem_address = addr;
        wdata       = wd;
        write       = wr;
        size        = sz;
        signed_load = sgn;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w <= waits; w++) begin
            check({tag, "/req"}, bus_if.bus_req, 1);
            check({tag, "/done_early"}, done, 0);
            if (w == 0 || w == waits) begin
                check({tag, "/addr"}, bus_if.bus_addr, exp_addr);
                check({tag, "/be"}, bus_if.bus_be, exp_be);
                check({tag, "/we"}, bus_if.bus_we, wr);
                check({tag, "/wdata"}, bus_if.bus_wdata, exp_wdata);
                check({tag, "/busy"}, busy, 1);
            end
            bus_if.bus_ack   = (w == waits);
            bus_if.bus_rdata = (w == waits) ? bus_rd : 32'h0BAD_0BAD;
            tick();
        end
        bus_if.bus_ack = 1'b0;
        check({tag, "/done"}, done, 1);
        check({tag, "/abort"}, abort, 0);
        check({tag, "/rdata"}, rdata, exp_rdata);
        check({tag, "/req_drop"}, bus_if.bus_req, 0);
        check({tag, "/busy_drop"}, busy, 0);
        tick();
        check({tag, "/done_pulse"}, done, 0);
    endtask

    task automatic bad_access(input string tag, input logic [31:0] addr, input logic [1:0] sz);
        mem_address = addr;
        write       = 1'b0;
        size        = sz;
        start       = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "/abort"}, abort, 1);
        check({tag, "/done"}, done, 0);
        check({tag, "/req"}, bus_if.bus_req, 0);
        check({tag, "/busy"}, busy, 0);
        tick();
        check({tag, "/abort_pulse"}, abort, 0);
        check({tag, "/req_after"}, bus_if.bus_req, 0);
    endtask

    initial begin
        int req_cycles;
        rst              = 1'b1;
        mem_address      = 32'd0;
        wdata            = 32'd0;
        start            = 1'b0;
        write            = 1'b0;
        size             = 2'b00;
        signed_load      = 1'b0;
        bus_if.bus_rdata = 32'd0;
        bus_if.bus_ack   = 1'b0;
        tick();
        check("rst/req", bus_if.bus_req, 0);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/abort", abort, 0);
        check("rst/rdata", rdata, 0);
        check("rst/be", bus_if.bus_be, 0);
        rst = 1'b0;
        tick();

        // Reset in the middle of an access drops bus_req without any pulse.
        mem_address = 32'h0000_0100;
        size        = 2'b10;
        start       = 1'b1;
        tick();
        start = 1'b0;
        check("midrst/req_before", bus_if.bus_req, 1);
        tick();
        rst = 1'b1;
        #1;
        check("midrst/req", bus_if.bus_req, 0);
        check("midrst/busy", busy, 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst/done", done, 0);
            check("midrst/abort", abort, 0);
        end
        check("midrst/rdata", rdata, 0);

        // Ack with no request outstanding must be ignored.
        bus_if.bus_ack = 1'b1;
        tick();
        bus_if.bus_ack = 1'b0;
        tick();
        check("stray_ack/done", done, 0);

        do_access("ld_w0", 32'h0000_1004, 32'd0, 1'b0, 2'b10, 1'b0, 0, 32'hDEAD_BEEF,
                  32'h0000_1004, 4'b1111, 32'd0, 32'hDEAD_BEEF);
        do_access("ld_bs3", 32'h0000_2003, 32'd0, 1'b0, 2'b00, 1'b1, 3, 32'h80FF_0011,
                  32'h0000_2000, 4'b1000, 32'd0, 32'hFFFF_FF80);
        do_access("ld_hs", 32'h0000_2002, 32'd0, 1'b0, 2'b01, 1'b1, 1, 32'h80FF_0011,
                  32'h0000_2000, 4'b1100, 32'd0, 32'hFFFF_80FF);
        do_access("ld_bu3", 32'h0000_2003, 32'd0, 1'b0, 2'b00, 1'b0, 3, 32'h80FF_0011,
                  32'h0000_2000, 4'b1000, 32'd0, 32'h0000_0080);
        do_access("st_h", 32'h0000_3002, 32'h1234_ABCD, 1'b1, 2'b01, 1'b0, 1, 32'hFFFF_FFFF,
                  32'h0000_3000, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080);
        do_access("st_b", 32'h0000_3001, 32'h0000_0055, 1'b1, 2'b00, 1'b0, 0, 32'hFFFF_FFFF,
                  32'h0000_3000, 4'b0010, 32'h5555_5555, 32'h0000_0080);

        bad_access("mis_w", 32'h0000_4001, 2'b10);
        bad_access("rsv_sz", 32'h0000_4000, 2'b11);
        bad_access("mis_h", 32'h0000_4001, 2'b01);

        // Timeout: no ack; a start in the middle of the access must not disturb it.
        mem_address = 32'h0000_5000;
        write       = 1'b0;
        size        = 2'b10;
        start       = 1'b1;
        tick();
        start      = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus_if.bus_req) break;
            req_cycles++;
            check("tmo/abort_early", abort, 0);
            if (i == 4) begin
                mem_address = 32'h0000_6000;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (i == 6) check("tmo/addr_held", bus_if.bus_addr, 32'h0000_5000);
            tick();
        end
        start = 1'b0;
        check("tmo/req_cycles", req_cycles, 16);
        check("tmo/abort", abort, 1);
        check("tmo/done", done, 0);
        check("tmo/busy", busy, 0);
        check("tmo/rdata", rdata, 32'h0000_0080);
        tick();
        check("tmo/abort_pulse", abort, 0);
        check("tmo/req_idle", bus_if.bus_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
